// File: rtl/sc_mon.sv
// sc_mon: checker for the saturating counter stage.
// Predicts the legal count sequence, reports completed runs and faults as
// event records through a 2-entry valid/ready buffer.
// Optional build macro: SC_MON_STATS_EN builds the saturation-entry counter.
module sc_mon (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] cnt,
    input  logic       cnt_err,
    input  logic       ctr_rst,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [1:0] ev_code,
    output logic [7:0] ev_data,
    output logic       err,
    output logic       ovf,
    output logic [7:0] sat_count
);

    localparam int unsigned CNT_W  = 3;
    localparam int unsigned DATA_W = 8;

    localparam logic [1:0] EV_DWELL    = 2'b00;
    localparam logic [1:0] EV_ABORT    = 2'b01;
    localparam logic [1:0] EV_MISMATCH = 2'b10;
    localparam logic [1:0] EV_CNTERR   = 2'b11;

    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(5);
    localparam logic [DATA_W-1:0] DWELL_MAX = DATA_W'(255);

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_RUN   = 2'd1,
        ST_SAT   = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    typedef struct packed {
        logic [1:0]        code;
        logic [DATA_W-1:0] data;
    } ev_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_prev;
    logic              r_first;
    logic              r_prev_crst;
    logic [DATA_W-1:0] r_dwell;
    logic [DATA_W-1:0] w_dwell_nxt;
    logic [DATA_W-1:0] w_dwell_inc;
    logic [CNT_W-1:0]  w_exp;
    logic              w_push;
    logic              w_fault;
    ev_t               w_push_ev;
    logic              w_pop;
    logic              r_head_v;
    ev_t               r_head;
    logic              r_tail_v;
    ev_t               r_tail;
    logic              r_err;
    logic              r_ovf;

    // Expected counter value for this edge
    always_comb begin
        w_exp = '0;
        if (ctr_rst || r_first || r_prev_crst) begin
            w_exp = '0;
        end else if (r_prev >= CNT_W'(4)) begin
            w_exp = CNT_MAX;
        end else begin
            w_exp = r_prev + CNT_W'(1);
        end
    end

    assign w_dwell_inc = (r_dwell == DWELL_MAX) ? DWELL_MAX : r_dwell + DATA_W'(1);

    // Monitor state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_SYNC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, checking and event generation
    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_push_ev   = '0;
        w_fault     = 1'b0;
        w_dwell_nxt = r_dwell;
        case (r_state)
            ST_SYNC: begin
                if (!ctr_rst && (cnt == '0)) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN, ST_SAT: begin
                if (cnt_err) begin
                    w_push      = 1'b1;
                    w_push_ev   = '{code: EV_CNTERR, data: {5'b0, cnt}};
                    w_fault     = 1'b1;
                    w_state_nxt = ST_FAULT;
                end else if (cnt != w_exp) begin
                    w_push      = 1'b1;
                    w_push_ev   = '{code: EV_MISMATCH, data: {2'b0, w_exp, cnt}};
                    w_fault     = 1'b1;
                    w_state_nxt = ST_FAULT;
                end else if (ctr_rst) begin
                    w_push      = 1'b1;
                    w_dwell_nxt = '0;
                    w_state_nxt = ST_RUN;
                    if (r_state == ST_RUN) begin
                        w_push_ev = '{code: EV_ABORT, data: {5'b0, r_prev}};
                    end else begin
                        // Dwell includes the terminating cycle spent in SAT
                        w_push_ev = '{code: EV_DWELL, data: w_dwell_inc};
                    end
                end else if ((r_state == ST_RUN) && (cnt == CNT_MAX)) begin
                    w_dwell_nxt = '0;
                    w_state_nxt = ST_SAT;
                end else if (r_state == ST_SAT) begin
                    w_dwell_nxt = w_dwell_inc;
                end
            end
            ST_FAULT: begin
                if (ctr_rst) begin
                    w_state_nxt = ST_SYNC;
                end
            end
            default: begin
                w_state_nxt = ST_SYNC;
            end
        endcase
    end

    // Sample history, dwell counter and sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev      <= '0;
            r_first     <= 1'b1;
            r_prev_crst <= 1'b0;
            r_dwell     <= '0;
            r_err       <= 1'b0;
        end else begin
            r_prev      <= cnt;
            r_first     <= 1'b0;
            r_prev_crst <= ctr_rst;
            r_dwell     <= w_dwell_nxt;
            if (w_fault) begin
                r_err <= 1'b1;
            end
        end
    end

    assign w_pop = r_head_v && ev_ready;

    // Two-entry event buffer held as head/tail registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head_v <= 1'b0;
            r_head   <= '0;
            r_tail_v <= 1'b0;
            r_tail   <= '0;
            r_ovf    <= 1'b0;
        end else if (w_pop) begin
            if (r_tail_v) begin
                r_head <= r_tail;
                if (w_push) begin
                    r_tail <= w_push_ev;
                end else begin
                    r_tail_v <= 1'b0;
                end
            end else if (w_push) begin
                r_head <= w_push_ev;
            end else begin
                r_head_v <= 1'b0;
            end
        end else if (w_push) begin
            if (!r_head_v) begin
                r_head_v <= 1'b1;
                r_head   <= w_push_ev;
            end else if (!r_tail_v) begin
                r_tail_v <= 1'b1;
                r_tail   <= w_push_ev;
            end else begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign ev_valid = r_head_v;
    assign ev_code  = r_head.code;
    assign ev_data  = r_head.data;
    assign err      = r_err;
    assign ovf      = r_ovf;

`ifdef SC_MON_STATS_EN
    logic [DATA_W-1:0] r_sat_count;
    logic              w_sat_enter;

    assign w_sat_enter = (r_state == ST_RUN) && (w_state_nxt == ST_SAT);

    // Saturation-entry counter, wraps at 255
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sat_count <= '0;
        end else if (w_sat_enter) begin
            r_sat_count <= r_sat_count + DATA_W'(1);
        end
    end

    assign sat_count = r_sat_count;
`else
    assign sat_count = '0;
`endif

endmodule

// File: tb/tb_sc_mon.sv
// Self-checking bench for sc_mon: directed scenarios plus randomized traffic
// against a behavioural model of the counter rules and event queue.
module tb_sc_mon;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] cnt = 3'd0;
    logic       cnt_err = 1'b0;
    logic       ctr_rst = 1'b0;
    logic       ev_valid;
    logic       ev_ready = 1'b0;
    logic [1:0] ev_code;
    logic [7:0] ev_data;
    logic       err;
    logic       ovf;
    logic [7:0] sat_count;

    int n_vec = 0;
    int n_bad = 0;

    sc_mon dut (
        .clk      (clk),
        .rst      (rst),
        .cnt      (cnt),
        .cnt_err  (cnt_err),
        .ctr_rst  (ctr_rst),
        .ev_valid (ev_valid),
        .ev_ready (ev_ready),
        .ev_code  (ev_code),
        .ev_data  (ev_data),
        .err      (err),
        .ovf      (ovf),
        .sat_count(sat_count)
    );

    always #5 clk = ~clk;

    // Behavioural model
    localparam int M_SYNC  = 0;
    localparam int M_RUN   = 1;
    localparam int M_SAT   = 2;
    localparam int M_FAULT = 3;

    int         m_mode = M_SYNC;
    int         m_prev = 0;
    bit         m_first = 1'b1;
    bit         m_pcr = 1'b0;
    int         m_dwell = 0;
    int         m_sat = 0;
    bit         m_err = 1'b0;
    bit         m_ovf = 1'b0;
    logic [9:0] m_q[$];

    function automatic logic [7:0] exp_sat();
`ifdef SC_MON_STATS_EN
        return 8'(m_sat);
`else
        return 8'd0;
`endif
    endfunction

    task automatic model_update(input logic [2:0] c, input logic ce, input logic cr,
                                input logic rdy, input logic r);
        int         e;
        int         nmode;
        bit         push;
        logic [9:0] rec;
        logic [9:0] dropped;
        if (r) begin
            m_mode = M_SYNC; m_prev = 0; m_first = 1'b1; m_pcr = 1'b0;
            m_dwell = 0; m_sat = 0; m_err = 1'b0; m_ovf = 1'b0;
            m_q.delete();
            return;
        end
        e     = (cr || m_first || m_pcr) ? 0 : ((m_prev + 1 > 5) ? 5 : m_prev + 1);
        nmode = m_mode;
        push  = 1'b0;
        rec   = '0;
        case (m_mode)
            M_SYNC: if (!cr && c == 3'd0) nmode = M_RUN;
            M_RUN, M_SAT: begin
                if (ce) begin
                    push = 1'b1; rec = {2'b11, 5'b0, c}; m_err = 1'b1; nmode = M_FAULT;
                end else if (int'(c) != e) begin
                    push = 1'b1; rec = {2'b10, 2'b00, 3'(e), c}; m_err = 1'b1; nmode = M_FAULT;
                end else if (cr) begin
                    push = 1'b1; nmode = M_RUN;
                    if (m_mode == M_RUN) rec = {2'b01, 5'b0, 3'(m_prev)};
                    else rec = {2'b00, 8'((m_dwell >= 255) ? 255 : m_dwell + 1)};
                    m_dwell = 0;
                end else if (m_mode == M_RUN && c == 3'd5) begin
                    nmode = M_SAT; m_dwell = 0; m_sat = (m_sat + 1) % 256;
                end else if (m_mode == M_SAT) begin
                    m_dwell = (m_dwell >= 255) ? 255 : m_dwell + 1;
                end
            end
            default: if (cr) nmode = M_SYNC;
        endcase
        if (m_q.size() > 0 && rdy) dropped = m_q.pop_front();
        if (push) begin
            if (m_q.size() < 2) m_q.push_back(rec);
            else m_ovf = 1'b1;
        end
        m_prev = int'(c); m_first = 1'b0; m_pcr = cr; m_mode = nmode;
    endtask

    // Drive one cycle of inputs, advance the model, sample after the edge
    task automatic step(input logic [2:0] c, input logic ce, input logic cr,
                        input logic rdy, input logic r);
        cnt = c; cnt_err = ce; ctr_rst = cr; ev_ready = rdy; rst = r;
        model_update(c, ce, cr, rdy, r);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step(3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic run_up(input int top);
        for (int v = 0; v <= top; v++) step(3'(v), 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        run_up(1);
        step(3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        step(3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        n_vec++; if (ev_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", ev_valid); end
        n_vec++; if (ev_code !== 2'd0) begin n_bad++; $display("FAIL reset_code: got %0d want 0", ev_code); end
        n_vec++; if (ev_data !== 8'd0) begin n_bad++; $display("FAIL reset_data: got %h want 00", ev_data); end
        n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
        n_vec++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        n_vec++; if (sat_count !== 8'd0) begin n_bad++; $display("FAIL reset_sat: got %0d want 0", sat_count); end
    endtask

    task automatic test_dwell();
        do_reset();
        run_up(5);
        for (int k = 0; k < 3; k++) step(3'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        n_vec++; if (ev_valid !== 1'b0) begin n_bad++; $display("FAIL dwell_pre_valid: got %b want 0", ev_valid); end
        step(3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        n_vec++; if (ev_valid !== 1'b1) begin n_bad++; $display("FAIL dwell_valid: got %b want 1", ev_valid); end
        n_vec++; if ({ev_code, ev_data} !== {2'b00, 8'd4}) begin n_bad++; $display("FAIL dwell_rec: got %0d/%h want 0/04", ev_code, ev_data); end
        n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL dwell_err: got %b want 0", err); end
        n_vec++; if (sat_count !== exp_sat()) begin n_bad++; $display("FAIL dwell_sat: got %0d want %0d", sat_count, exp_sat()); end
        step(3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        n_vec++; if (ev_valid !== 1'b0) begin n_bad++; $display("FAIL dwell_pop: got %b want 0", ev_valid); end
    endtask

    task automatic test_dwell_sat();
        do_reset();
        run_up(5);
        for (int k = 0; k < 300; k++) step(3'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        step(3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        n_vec++; if ({ev_code, ev_data} !== {2'b00, 8'd255}) begin n_bad++; $display("FAIL dwell_sat255: got %0d/%h want 0/ff", ev_code, ev_data); end
    endtask

    task automatic test_abort();
        do_reset();
        run_up(2);
        step(3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        n_vec++; if ({ev_valid, ev_code, ev_data} !== {1'b1, 2'b01, 8'd2}) begin n_bad++; $display("FAIL abort_rec: got %b/%0d/%h want 1/1/02", ev_valid, ev_code, ev_data); end
        step(3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        n_vec++; if ({ev_valid, err} !== 2'b00) begin n_bad++; $display("FAIL abort_resume: got valid=%b err=%b want 0 0", ev_valid, err); end
        step(3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        n_vec++; if ({ev_code, ev_data} !== {2'b10, 8'h13}) begin n_bad++; $display("FAIL abort_still_run: got %0d/%h want 2/13", ev_code, ev_data); end
    endtask

    task automatic test_mismatch();
        do_reset();
        run_up(1);
        step(3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        n_vec++; if ({ev_valid, ev_code, ev_data} !== {1'b1, 2'b10, 8'h13}) begin n_bad++; $display("FAIL mm_rec: got %b/%0d/%h want 1/2/13", ev_valid, ev_code, ev_data); end
        n_vec++; if (err !== 1'b1) begin n_bad++; $display("FAIL mm_err: got %b want 1", err); end
        step(3'd7, 1'b1, 1'b0, 1'b1, 1'b0);
        step(3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        step(3'd6, 1'b0, 1'b0, 1'b0, 1'b0);
        n_vec++; if ({ev_valid, err} !== 2'b01) begin n_bad++; $display("FAIL mm_fault_quiet: got valid=%b err=%b want 0 1", ev_valid, err); end
        step(3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        n_vec++; if (ev_valid !== 1'b0) begin n_bad++; $display("FAIL mm_sync_nocheck: got %b want 0", ev_valid); end
        run_up(1);
        step(3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        n_vec++; if ({ev_valid, ev_code, ev_data} !== {1'b1, 2'b10, 8'h13}) begin n_bad++; $display("FAIL mm_resync: got %b/%0d/%h want 1/2/13", ev_valid, ev_code, ev_data); end
    endtask

    task automatic test_cnterr();
        do_reset();
        run_up(1);
        step(3'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        n_vec++; if ({ev_valid, ev_code, ev_data} !== {1'b1, 2'b11, 8'h04}) begin n_bad++; $display("FAIL cnterr_rec: got %b/%0d/%h want 1/3/04", ev_valid, ev_code, ev_data); end
        n_vec++; if ({err, ovf} !== 2'b10) begin n_bad++; $display("FAIL cnterr_flags: got err=%b ovf=%b want 1 0", err, ovf); end
        step(3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        n_vec++; if (ev_valid !== 1'b0) begin n_bad++; $display("FAIL cnterr_single: got %b want 0", ev_valid); end
    endtask

    // Fill the buffer with ABORT(2) then ABORT(0)
    task automatic fill_two();
        do_reset();
        run_up(2);
        step(3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_overflow();
        fill_two();
        step(3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        n_vec++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_set: got %b want 1", ovf); end
        n_vec++; if ({ev_code, ev_data} !== {2'b01, 8'd2}) begin n_bad++; $display("FAIL ovf_head0: got %0d/%h want 1/02", ev_code, ev_data); end
        step(3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        n_vec++; if ({ev_valid, ev_code, ev_data} !== {1'b1, 2'b01, 8'd0}) begin n_bad++; $display("FAIL ovf_head1: got %b/%0d/%h want 1/1/00", ev_valid, ev_code, ev_data); end
        step(3'd1, 1'b0, 1'b0, 1'b1, 1'b0);
        n_vec++; if ({ev_valid, ovf, err} !== 3'b010) begin n_bad++; $display("FAIL ovf_drain: got valid=%b ovf=%b err=%b want 0 1 0", ev_valid, ovf, err); end
    endtask

    task automatic test_full_push_pop();
        fill_two();
        step(3'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        n_vec++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL fpp_ovf: got %b want 0", ovf); end
        n_vec++; if ({ev_code, ev_data} !== {2'b01, 8'd0}) begin n_bad++; $display("FAIL fpp_head0: got %0d/%h want 1/00", ev_code, ev_data); end
        step(3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        n_vec++; if ({ev_valid, ev_code, ev_data} !== {1'b1, 2'b01, 8'd1}) begin n_bad++; $display("FAIL fpp_head1: got %b/%0d/%h want 1/1/01", ev_valid, ev_code, ev_data); end
        step(3'd1, 1'b0, 1'b0, 1'b1, 1'b0);
        n_vec++; if ({ev_valid, ovf} !== 2'b00) begin n_bad++; $display("FAIL fpp_drain: got valid=%b ovf=%b want 0 0", ev_valid, ovf); end
    endtask

    task automatic test_sat_wrap();
        do_reset();
        for (int run = 0; run < 256; run++) begin
            for (int v = 0; v <= 5; v++) step(3'(v), 1'b0, 1'b0, 1'b1, 1'b0);
            step(3'd0, 1'b0, 1'b1, 1'b1, 1'b0);
            n_vec++; if ({sat_count, err} !== {exp_sat(), 1'b0}) begin n_bad++; $display("FAIL sat_wrap run %0d: got %0d err=%b want %0d err=0", run, sat_count, err, exp_sat()); end
        end
    endtask

    task automatic test_random();
        int         gprev;
        bit         gpcr;
        logic [2:0] c;
        logic       ce, cr, rdy, r;
        do_reset();
        gprev = 0; gpcr = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            r   = ($urandom % 300) == 0;
            cr  = ($urandom % 8) == 0;
            c   = (cr || gpcr) ? 3'd0 : 3'((gprev + 1 > 5) ? 5 : gprev + 1);
            if (($urandom % 25) == 0) c = 3'($urandom % 8);
            ce  = ($urandom % 50) == 0;
            rdy = ($urandom % 2) == 0;
            step(c, ce, cr, rdy, r);
            gprev = int'(c); gpcr = cr || r;
            n_vec++; if (ev_valid !== (m_q.size() > 0)) begin n_bad++; $display("FAIL rnd_valid @%0d: got %b want %b", i, ev_valid, m_q.size() > 0); end
            if (m_q.size() > 0) begin
                n_vec++; if ({ev_code, ev_data} !== m_q[0]) begin n_bad++; $display("FAIL rnd_rec @%0d: got %0d/%h want %0d/%h", i, ev_code, ev_data, m_q[0][9:8], m_q[0][7:0]); end
            end
            n_vec++; if ({err, ovf} !== {m_err, m_ovf}) begin n_bad++; $display("FAIL rnd_flags @%0d: got err=%b ovf=%b want %b %b", i, err, ovf, m_err, m_ovf); end
            n_vec++; if (sat_count !== exp_sat()) begin n_bad++; $display("FAIL rnd_sat @%0d: got %0d want %0d", i, sat_count, exp_sat()); end
        end
    endtask

    initial begin
        test_reset();
        test_dwell();
        test_dwell_sat();
        test_abort();
        test_mismatch();
        test_cnterr();
        test_overflow();
        test_full_push_pop();
        test_sat_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/sc_mon.md
# sc_mon

Downstream checker for the saturating counter stage: samples the counter's `out`/`err` pair and the `ctr_rst` it is driven with every cycle. Predicts the legal count sequence (0,1,2,3,4,5,5,…; back to 0 on `ctr_rst`) and flags divergence. Emits one event record per completed run or fault through a 2-entry valid/ready buffer for a logger or host-visible register stage.

## Interface
- No parameters; all widths fixed.
- `clk` input 1: system clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `cnt` input 3: counter `out` value, sampled each edge.
- `cnt_err` input 1: counter `err` flag.
- `ctr_rst` input 1: the same `ctr_rst` the counter sees this cycle.
- `ev_valid` output 1: event record available at buffer head.
- `ev_ready` input 1: consumer accepts head when `ev_valid && ev_ready` at an edge.
- `ev_code` output 2: 00 DWELL, 01 ABORT, 10 MISMATCH, 11 CNTERR.
- `ev_data` output 8: event payload, defined per code below.
- `err` output 1: sticky; set on any MISMATCH or CNTERR event, cleared only by `rst`.
- `ovf` output 1: sticky; set when an event is dropped because the buffer is full, cleared only by `rst`.
- `sat_count` output 8: saturation-entry count, feature-gated (see Configuration).

## Operation
- Expected value `exp`, computed combinationally from registered state:
  - `ctr_rst`=1: `exp`=0.
  - First cycle after `rst`, or previous cycle had `ctr_rst`=1: `exp`=0.
  - Otherwise: `exp`=min(`prev`+1, 5), where `prev` is last sampled `cnt`.
- FSM states: SYNC, RUN, SAT, FAULT. Reset state is SYNC.
  - SYNC: waits for a cycle with `ctr_rst`=0 and `cnt`=0, then goes to RUN. No checking in SYNC.
  - RUN: on `cnt`=5 and `cnt`==`exp`, go to SAT, clear dwell counter, increment `sat_count`.
  - SAT: dwell counter increments each cycle (saturates at 255).
  - Any checked state, `ctr_rst`=1, no fault:
    - From RUN: push ABORT, `ev_data`={5'b0,`prev`}.
    - From SAT: push DWELL, `ev_data`=dwell count.
    - Next state RUN.
  - Fault priority, highest first:
    - `cnt_err`=1: push CNTERR, `ev_data`={5'b0,`cnt`}.
    - `cnt`!=`exp`: push MISMATCH, `ev_data`={2'b0,`exp`,`cnt`}.
    - Either fault sets `err` and moves to FAULT. At most one event per cycle.
  - FAULT: no checking and no events. On `ctr_rst`=1 go to SYNC.
- Event buffer: 2-entry FIFO.
  - Push and pop in the same cycle are both allowed, including when full.
  - Push while full with no pop: record dropped, `ovf` set.
- Reset values: state SYNC, `prev`=0, dwell=0, buffer empty, `ev_valid`=0, `ev_code`=0, `ev_data`=0, `err`=0, `ovf`=0, `sat_count`=0.
- `rst` mid-run discards buffered events and drops the in-flight dwell.

## Timing
- Inputs are sampled on the rising edge; every decision uses that edge's inputs.
- An event pushed at edge N is visible at the head (`ev_valid`=1) after edge N when the buffer was empty: one cycle latency.
- `ev_code`/`ev_data` hold stable while `ev_valid`=1 and `ev_ready`=0.
- `err`, `ovf` and `sat_count` update at the same edge as the triggering sample.
- `sat_count` wraps 255→0.
- Dwell is reported saturated at 255.

## Configuration
- `SC_MON_STATS_EN` defined: the `sat_count` 8-bit register and its increment logic are built.
- Not defined: `sat_count` is tied to 0 and no register is inferred. All other behaviour is identical.

## Test plan
- Reset, drive legal 0..5 then three cycles at 5, then `ctr_rst` -> one DWELL event with `ev_data`=4, `err`=0, `sat_count`=1 (when `SC_MON_STATS_EN` is defined).
- Legal 0,1,2 then `ctr_rst` -> ABORT with `ev_data`=2, state RUN, next 0,1 accepted without error.
- In RUN, drive 0,1,3 -> MISMATCH with `ev_data`=8'h13 (exp 2, obs 3), `err`=1; further garbage produces no events until `ctr_rst`, then SYNC.
- Assert `cnt_err` together with a mismatched `cnt` -> only CNTERR is pushed, `ev_data`=`cnt`.
- Hold `ev_ready`=0 and generate three ABORT events -> the first two are retained in order, `ovf`=1. Then `ev_ready`=1 -> two pops, `ev_valid`=0.
- Buffer full, with push and `ev_ready`=1 on the same edge -> no drop, `ovf` stays 0, order preserved.
